// File: rtl/counter_run_scheduler_if.sv
// Bundle between the counter run scheduler, its requesters and the shared
// wrap counter. Parameters must match those of counter_run_scheduler.
interface counter_run_scheduler_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4,
    parameter int LW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] len;
    logic               abort;
    logic [CW-1:0]      count_in;
    logic               start;
    logic               stop;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               done;
    logic [2:0]         done_id;
    logic [CW-1:0]      final_count;
    logic               aborted;

    modport master (
        output req, len, abort, count_in,
        input  start, stop, grant, busy, done, done_id, final_count, aborted
    );

    modport slave (
        input  req, len, abort, count_in,
        output start, stop, grant, busy, done, done_id, final_count, aborted
    );
endinterface

// File: rtl/counter_run_scheduler.sv
// Round-robin scheduler that lends one start/stop wrap counter to NREQ
// requesters for runs of a fixed number of increments.
module counter_run_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 4,
    parameter int LW   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    counter_run_scheduler_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STOP,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          flag_q, flag_d;
    logic [2:0]    did_q, did_d;
    logic [CW-1:0] fc_q, fc_d;
    logic          ab_q, ab_d;

    logic          found;
    logic [IW-1:0] pick;
    logic [LW-1:0] pick_len;
    logic [NREQ-1:0] owner_oh;

    // Round-robin search: first pending request above the last winner, wrapping.
    always_comb begin
        logic [IW-1:0] idx;
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_len = bus.len[int'(pick)*LW +: LW];
    end

    // One-hot view of the current owner.
    always_comb begin
        owner_oh = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Run bookkeeping and the held completion report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= '0;
            ptr_q   <= IW'(NREQ - 1);
            len_q   <= '0;
            rem_q   <= '0;
            flag_q  <= 1'b0;
            did_q   <= '0;
            fc_q    <= '0;
            ab_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            flag_q  <= flag_d;
            did_q   <= did_d;
            fc_q    <= fc_d;
            ab_q    <= ab_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        rem_d   = rem_q;
        flag_d  = flag_q;
        did_d   = did_q;
        fc_d    = fc_q;
        ab_d    = ab_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d = pick;
                    ptr_d   = pick;
                    len_d   = (pick_len == '0) ? LW'(1) : pick_len;
                    state_d = S_START;
                end
            end
            S_START: begin
                rem_d   = len_q - LW'(1);
                state_d = (len_q == LW'(1)) ? S_STOP : S_RUN;
            end
            S_RUN: begin
                rem_d = rem_q - LW'(1);
                if (rem_q == LW'(1) || bus.abort || !bus.req[owner_q]) begin
                    state_d = S_STOP;
                    flag_d  = (rem_q != LW'(1));
                end
            end
            S_STOP: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                did_d   = 3'(owner_q);
                fc_d    = bus.count_in;
                ab_d    = flag_q;
                flag_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; report fields are live during DONE.
    always_comb begin
        bus.start       = (state_q == S_START);
        bus.stop        = (state_q == S_STOP);
        bus.busy        = (state_q != S_IDLE);
        bus.done        = (state_q == S_DONE);
        bus.grant       = '0;
        if (state_q == S_START || state_q == S_RUN || state_q == S_STOP)
            bus.grant = owner_oh;
        bus.done_id     = did_q;
        bus.final_count = fc_q;
        bus.aborted     = ab_q;
        if (state_q == S_DONE) begin
            bus.done_id     = 3'(owner_q);
            bus.final_count = bus.count_in;
            bus.aborted     = flag_q;
        end
    end
endmodule

// File: tb/tb_counter_run_scheduler.sv
// Bench for counter_run_scheduler with a modelled wrap counter (modulo 14)
// and a queue of expected completions.
module tb_counter_run_scheduler;
    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int LW   = 8;
    localparam int WRAP = 13;

    typedef struct {
        int id;
        int inc;
        int fc;
        int ab;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ld;
    logic [CW-1:0] ld_val;
    logic [CW-1:0] cnt;
    logic en;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st_cyc = 0;
    int done_cyc = -1;
    int busy_cnt = 0;
    int exp_cnt = 0;
    bit b2b = 1'b0;

    counter_run_scheduler_if #(.NREQ(NREQ), .CW(CW), .LW(LW)) bus ();

    counter_run_scheduler #(.NREQ(NREQ), .CW(CW), .LW(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared wrap counter: enabled by start, disabled by stop.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            en  <= 1'b0;
        end else if (ld) begin
            cnt <= ld_val;
            en  <= 1'b0;
        end else begin
            if (en) cnt <= (cnt == CW'(WRAP)) ? '0 : cnt + 1'b1;
            if (bus.start) en <= 1'b1;
            else if (bus.stop) en <= 1'b0;
        end
    end

    assign bus.count_in = cnt;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input int inc, input int ab);
        exp_t e;
        e.id  = id;
        e.inc = inc;
        e.ab  = ab;
        e.fc  = (exp_cnt + inc) % (WRAP + 1);
        exp_cnt = e.fc;
        sb.push_back(e);
    endtask

    task automatic set_len(input int i, input int v);
        bus.len[i*LW +: LW] = LW'(v);
    endtask

    task automatic load_cnt(input int v);
        @(posedge clk); #1;
        ld = 1'b1;
        ld_val = CW'(v);
        @(posedge clk); #1;
        ld = 1'b0;
        exp_cnt = v;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, int'(bus.start), 0);
        chk({tag, "_stop"}, int'(bus.stop), 0);
        chk({tag, "_grant"}, int'(bus.grant), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_id"}, int'(bus.done_id), 0);
        chk({tag, "_fc"}, int'(bus.final_count), 0);
        chk({tag, "_ab"}, int'(bus.aborted), 0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.done) break;
        end
        chk("done_wait", int'(bus.done), 1);
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.start) break;
        end
        chk("start_wait", int'(bus.start), 1);
    endtask

    // Pulse-level monitor: run length, grant, spacing and completion report.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy) busy_cnt++;
            if (bus.start && bus.stop) chk("start_stop_excl", 1, 0);
            if (bus.start) begin
                st_cyc = cyc;
                if (sb.size() == 0) chk("start_unexp", int'(bus.start), 0);
                else chk("start_grant", int'(bus.grant), 1 << sb[0].id);
                if (b2b && done_cyc >= 0) chk("b2b_gap", cyc - done_cyc, 2);
            end
            if (bus.stop && sb.size() != 0) begin
                chk("run_len", cyc - st_cyc, sb[0].inc);
                chk("stop_grant", int'(bus.grant), 1 << sb[0].id);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("done_unexp", int'(bus.done), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_id", int'(bus.done_id), e.id);
                    chk("final_count", int'(bus.final_count), e.fc);
                    chk("aborted", int'(bus.aborted), e.ab);
                    chk("busy_cycles", busy_cnt, e.inc + 2);
                    chk("done_grant", int'(bus.grant), 0);
                end
                busy_cnt = 0;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        reset = 1'b1;
        ld = 1'b0;
        ld_val = '0;
        bus.req = '0;
        bus.len = '0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        reset = 1'b0;

        // single run of 5 from 0; owner len change after grant is ignored
        load_cnt(0);
        set_len(0, 5);
        push_exp(0, 5, 0);
        bus.req = 4'b0001;
        wait_start(20);
        set_len(0, 2);
        wait_done(20);
        bus.req = '0;

        // wrap: 5 + 20 mod 14
        load_cnt(5);
        set_len(1, 20);
        push_exp(1, 20, 0);
        bus.req = 4'b0010;
        wait_done(40);
        bus.req = '0;
        chk("held_id", int'(bus.done_id), 1);

        // round robin after reset
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_zero("rst2");
        exp_cnt = 0;
        busy_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        push_exp(0, 2, 0);
        push_exp(1, 2, 0);
        push_exp(3, 2, 0);
        push_exp(0, 2, 0);
        push_exp(1, 2, 0);
        push_exp(3, 2, 0);
        done_cyc = -1;
        b2b = 1'b1;
        bus.req = 4'b1011;
        for (int k = 0; k < 6; k++) wait_done(20);
        bus.req = '0;
        b2b = 1'b0;

        // abort in the third RUN cycle
        set_len(0, 10);
        push_exp(0, 4, 1);
        bus.req = 4'b0001;
        wait_start(20);
        repeat (3) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        wait_done(20);
        bus.req = '0;

        // same early exit by dropping the owner's request
        push_exp(0, 4, 1);
        bus.req = 4'b0001;
        wait_start(20);
        repeat (3) @(posedge clk);
        #1;
        bus.req = '0;
        wait_done(20);

        // len 0 behaves as len 1
        set_len(0, 0);
        push_exp(0, 1, 0);
        bus.req = 4'b0001;
        wait_done(20);
        bus.req = '0;

        // len 1 with abort held outside RUN
        set_len(0, 1);
        push_exp(0, 1, 0);
        bus.abort = 1'b1;
        bus.req = 4'b0001;
        wait_done(20);
        bus.req = '0;
        bus.abort = 1'b0;

        // reset in the middle of a len 9 run
        set_len(0, 9);
        push_exp(0, 9, 0);
        bus.req = 4'b0001;
        wait_start(20);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        sb.delete();
        busy_cnt = 0;
        exp_cnt = 0;
        set_len(0, 3);
        set_len(2, 3);
        bus.req = 4'b0101;
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp(0, 3, 0);
        push_exp(2, 3, 0);
        wait_done(20);
        bus.req = 4'b0100;
        wait_done(20);
        bus.req = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("idle_busy", int'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_run_scheduler.md
Name: counter_run_scheduler

Overview:
- Shares one start/stop-enabled wrap counter (modulo WRAP+1, enable set by `start`, cleared by `stop`, asynchronous reset) among NREQ requesters.
- Each requester asks for a run of exactly `len` counter increments.
- The block arbitrates round-robin, drives single-cycle `start`/`stop` pulses at the counter, and times the run.
- At the end it reports a done pulse, the winning requester ID and the counter value after the run.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 4, width of the counter value input
- LW, 8, width of each requested run length

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request level; held high until granted run completes
- len  input  NREQ*LW  packed run lengths; requester i at bits [i*LW +: LW]; sampled at grant
- abort  input  1  terminates the current run early
- count_in  input  CW  current value of the shared counter
- start  output  1  one-cycle pulse to counter start
- stop  output  1  one-cycle pulse to counter stop
- grant  output  NREQ  one-hot owner of the counter, 0 when idle
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- done_id  output  3  index of the requester whose run completed; valid with done, held until next done
- final_count  output  CW  count_in captured on the done cycle; held until next done
- aborted  output  1  high with done when the run ended early; held until next done

Behaviour:
- Reset (async, any state):
  - state=IDLE; start, stop, grant, busy, done, aborted = 0; done_id=0; final_count=0.
  - RR pointer = NREQ-1, so req[0] has highest priority first.
  - Reset mid-run leaves no pulse pending; the counter receives its own reset separately.
- States: IDLE, START, RUN, STOP, DONE.
- IDLE:
  - If any req bit is set, select the first set bit scanning from ptr+1 upward, wrapping.
  - Set grant one-hot and ptr=selected.
  - Latch L = len of selected requester; L=0 is treated as 1.
  - Go to START. With no request, stay in IDLE.
- START:
  - start=1 for exactly this cycle.
  - Load remaining = L-1.
  - If L==1, go to STOP; else go to RUN.
- RUN:
  - start=stop=0.
  - Decrement remaining each cycle.
  - Go to STOP when remaining==1 at cycle start, or abort=1, or req[owner]=0.
  - An early exit sets an internal aborted flag.
- STOP:
  - stop=1 for exactly this cycle.
  - Go to DONE.
- DONE:
  - done=1 and grant=0.
  - Capture done_id=owner, final_count=count_in, aborted=flag.
  - Clear flag and go to IDLE.
  - A new grant is possible on the following cycle, so back-to-back runs have a 1-cycle IDLE gap.
- Timing:
  - With START in cycle t and no early exit, STOP occurs in cycle t+L.
  - The counter therefore increments on edges t+1..t+L, exactly L increments.
  - final_count = (count before run + L) mod (WRAP+1).
  - grant stays high from START through STOP inclusive.
- start and stop are never asserted in the same cycle. abort outside RUN is ignored.
- Request changes:
  - req changes of non-owners during a run have no effect.
  - len of the owner changing after grant has no effect.
- Simultaneous requests resolve by RR.
  - The winner becomes lowest priority for the next arbitration.
  - A requester holding req through done is granted again only if no other requester is pending.

Test Plan:
- Single run:
  - Stimulus: counter at 0; req[0]=1, len0=5.
  - Response: start pulse, then stop pulse exactly 5 cycles later; done with done_id=0, final_count=5, aborted=0; busy for 7 cycles.
- Wrap:
  - Stimulus: counter at 5; req[1]=1, len1=20.
  - Response: done_id=1, final_count=(5+20) mod 14 = 11.
- Round-robin:
  - Stimulus: req=4'b1011 held, all len=2.
  - Response: grant order 0,1,3,0,1,3; each done separated by 1 IDLE cycle.
- Abort:
  - Stimulus: len0=10; abort asserted in the 3rd RUN cycle.
  - Response: stop next cycle, done with aborted=1, counter advanced by 4.
  - Repeat with the req[0] drop instead of abort: same result.
- len=0 and len=1:
  - Response: both give START then STOP in consecutive cycles, one increment, aborted=0.
- Reset mid-run:
  - Stimulus: assert reset during RUN of a len=9 run.
  - Response: outputs 0 immediately; after release, a pending req[2] together with req[0] grants req[0] first.
